force_cache_drain: RTL and testbench
====================================

Name: force_cache_drain

Overview:
- Reader-side companion to force_cache.
- After a force-evaluation pass completes, it sequentially reads every particle entry from force_cache and streams each {Force_Z, Force_Y, Force_X} word to the motion-update unit over a valid/ready handshake.
- It optionally zeroes each entry behind the read, so the cache is clean for the next timestep.
- It absorbs the cache read latency and downstream backpressure with a credit-controlled skid FIFO.

Parameters:
- DATA_WIDTH, 96: cache word width, {Force_Z, Force_Y, Force_X}, 32 bits each.
- PARTICLE_NUM, 290: number of entries drained, addresses 0..PARTICLE_NUM-1.
- ADDR_WIDTH, 9: cache address width.
- RD_LATENCY, 1: cycles from cache_rd_address to valid cache_rd_data. Legal values 1..3.
- CLEAR_ON_READ, 1: 1 = write zero to each entry after it is read.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begin a drain pass.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse when the last entry is handshaken out.
- cache_rd_address  out  ADDR_WIDTH  to force_cache rdaddress.
- cache_rd_data  in  DATA_WIDTH  from force_cache q.
- cache_wr_address  out  ADDR_WIDTH  to force_cache wraddress (clear path).
- cache_wr_data  out  DATA_WIDTH  to force_cache data; always zero.
- cache_wr_enable  out  1  to force_cache wren.
- out_valid  out  1  out_data / out_particle_id valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  DATA_WIDTH  force word.
- out_particle_id  out  ADDR_WIDTH  address the word came from.
- out_last  out  1  high with the entry PARTICLE_NUM-1.

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE; every output 0, including cache_rd_address, cache_wr_*, out_*, busy and done. Issue counter, latency pipe valids and FIFO are cleared. A drain in progress is abandoned; no partial done.
- FSM states:
  - IDLE: start=1 -> ISSUE with issue address 0. start in any other state is ignored.
  - ISSUE: issue one read per cycle while credit is available. After address PARTICLE_NUM-1 is issued -> FLUSH.
  - FLUSH: no new reads; wait until the latency pipe is empty and the FIFO is drained by handshakes. On the handshake of out_last -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy = (state != IDLE).
- Read issue: cache_rd_address = issue address. A read is issued in a cycle only if (in-flight reads + FIFO occupancy) < FIFO_DEPTH, where FIFO_DEPTH = RD_LATENCY+2. The issue address increments by 1 per issued read. cache_rd_address holds its value when not issuing.
- Latency pipe: RD_LATENCY-stage shift register of {valid, address}. When a valid reaches the end, cache_rd_data is captured into the FIFO together with that address. Overflow is impossible by the credit rule; the bench asserts this.
- Clear: when CLEAR_ON_READ=1, in the same cycle that a returned word is pushed into the FIFO, drive cache_wr_enable=1, cache_wr_address=that address, cache_wr_data=0. Otherwise cache_wr_enable stays 0.
  - The write completes 2 cycles later inside force_cache.
  - Each address is read exactly once per pass, so no read-after-clear hazard arises.
- Output:
  - out_valid = FIFO not empty; out_data / out_particle_id come from the FIFO head (first-word fall-through).
  - out_last = out_valid && (out_particle_id == PARTICLE_NUM-1).
  - Pop on out_valid && out_ready. A push and a pop in the same cycle keep occupancy unchanged.
  - Words leave strictly in address order 0..PARTICLE_NUM-1, each exactly once.
- Throughput: with out_ready held high, one word per cycle. The first out_valid appears RD_LATENCY+1 cycles after start. done arrives PARTICLE_NUM+RD_LATENCY+1 cycles after start.
- Backpressure: out_ready=0 for any number of cycles loses no data and issues no read beyond the credit limit. The read stream resumes within 1 cycle of out_ready rising.
- Widths: the issue counter is ADDR_WIDTH bits; PARTICLE_NUM <= 2^ADDR_WIDTH. The counter never wraps within a pass.

Test Plan:
- Preload cache[i]={i+2, i+1, i}, CLEAR_ON_READ=1, out_ready=1, pulse start -> 290 words out in order with ids 0..289; out_last only on id 289; done exactly once, 292 cycles after start; every cache entry reads 0 afterwards.
- Same preload, out_ready toggles 1/0 each cycle -> identical ordered sequence with no duplicates or gaps; FIFO occupancy never exceeds RD_LATENCY+2.
- out_ready=0 for 50 cycles starting at word 10 -> cache_rd_address stalls within RD_LATENCY+2 issues of word 10; words 10.. resume intact after out_ready rises.
- rst asserted mid-pass (at word 100) -> all outputs 0 immediately (asynchronous); no done; a new start then drains from address 0.
- start pulsed again while busy -> ignored; exactly one pass of 290 words and one done.
- RD_LATENCY=3, CLEAR_ON_READ=0 -> correct data and ordering; cache_wr_enable never asserted; cache contents unchanged.

Source files
------------

// File: rtl/force_cache_drain.sv
// Drains every force_cache entry in address order onto a valid/ready stream,
// optionally zeroing each entry behind the read. A credit-limited skid FIFO absorbs latency.
module force_cache_drain #(
    parameter int unsigned DATA_WIDTH    = 96,
    parameter int unsigned PARTICLE_NUM  = 290,
    parameter int unsigned ADDR_WIDTH    = 9,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned CLEAR_ON_READ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] cache_rd_address,
    input  logic [DATA_WIDTH-1:0] cache_rd_data,
    output logic [ADDR_WIDTH-1:0] cache_wr_address,
    output logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic                  cache_wr_enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_particle_id,
    output logic                  out_last
);

    localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
    localparam int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [CNT_WIDTH:0]    DEPTH_C   = (CNT_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0]  PTR_LAST  = PTR_WIDTH'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StFlush, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] issue_addr_q;
    logic                  busy_q;
    logic                  done_q;

    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LATENCY];

    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_id_q   [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [CNT_WIDTH-1:0]  fifo_cnt_q;

    logic [CNT_WIDTH-1:0]  inflight;
    logic [CNT_WIDTH:0]    credit_used;
    logic                  issue;
    logic                  push;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic                  head_valid;
    logic                  pop;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Reads in the pipe count against FIFO space so a returning word always has a slot.
    always_comb begin
        inflight    = CNT_WIDTH'($countones(pipe_vld_q));
        credit_used = {1'b0, inflight} + {1'b0, fifo_cnt_q};
        issue       = (state_q == StIssue) && (credit_used < DEPTH_C);
        push        = pipe_vld_q[RD_LATENCY-1];
        push_addr   = pipe_addr_q[RD_LATENCY-1];
        head_valid  = (fifo_cnt_q != '0);
        pop         = head_valid && out_ready;
    end

    always_comb begin
        busy             = busy_q;
        done             = done_q;
        cache_rd_address = issue_addr_q;
        cache_wr_enable  = (CLEAR_ON_READ != 0) && push;
        cache_wr_address = cache_wr_enable ? push_addr : '0;
        cache_wr_data    = '0;
        out_valid        = head_valid;
        out_data         = head_valid ? fifo_data_q[rd_ptr_q] : '0;
        out_particle_id  = head_valid ? fifo_id_q[rd_ptr_q] : '0;
        out_last         = head_valid && (fifo_id_q[rd_ptr_q] == LAST_ADDR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            issue_addr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StIssue;
                        issue_addr_q <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                StIssue: begin
                    // Address parks on the last entry instead of running past it.
                    if (issue) begin
                        if (issue_addr_q == LAST_ADDR) state_q <= StFlush;
                        else issue_addr_q <= issue_addr_q + 1'b1;
                    end
                end
                StFlush: begin
                    if (pop && out_last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_addr_q[i] <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
            pipe_vld_q[0]  <= issue;
            pipe_addr_q[0] <= issue_addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= cache_rd_data;
            fifo_id_q[wr_ptr_q]   <= push_addr;
        end
    end

endmodule

// File: tb/tb_force_cache_drain.sv
// Scoreboard bench for force_cache_drain: two instances (latency 1 with clear, latency 3
// without) each backed by a behavioural force_cache model.
module tb_force_cache_drain;

    localparam int DW      = 96;
    localparam int AW      = 9;
    localparam int N       = 290;
    localparam int LA      = 1;
    localparam int LB      = 3;
    localparam int DEPTH_A = LA + 2;

    typedef logic [AW+DW-1:0] ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_a = 1'b0, ready_a = 1'b0, busy_a, done_a, wen_a, valid_a, last_a;
    logic [AW-1:0] raddr_a, waddr_a, id_a;
    logic [DW-1:0] rdata_a, wdata_a, data_a;
    logic          start_b = 1'b0, ready_b = 1'b0, busy_b, done_b, wen_b, valid_b, last_b;
    logic [AW-1:0] raddr_b, waddr_b, id_b;
    logic [DW-1:0] rdata_b, wdata_b, data_b;

    force_cache_drain #(
        .DATA_WIDTH(DW), .PARTICLE_NUM(N), .ADDR_WIDTH(AW), .RD_LATENCY(LA), .CLEAR_ON_READ(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .cache_rd_address(raddr_a), .cache_rd_data(rdata_a), .cache_wr_address(waddr_a),
        .cache_wr_data(wdata_a), .cache_wr_enable(wen_a), .out_valid(valid_a),
        .out_ready(ready_a), .out_data(data_a), .out_particle_id(id_a), .out_last(last_a)
    );

    force_cache_drain #(
        .DATA_WIDTH(DW), .PARTICLE_NUM(N), .ADDR_WIDTH(AW), .RD_LATENCY(LB), .CLEAR_ON_READ(0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .cache_rd_address(raddr_b), .cache_rd_data(rdata_b), .cache_wr_address(waddr_b),
        .cache_wr_data(wdata_b), .cache_wr_enable(wen_b), .out_valid(valid_b),
        .out_ready(ready_b), .out_data(data_b), .out_particle_id(id_b), .out_last(last_b)
    );

    function automatic logic [DW-1:0] fill(input int i);
        return {32'(i + 2), 32'(i + 1), 32'(i)};
    endfunction

    // force_cache models: registered read address, RD_LATENCY total, writes land 2 cycles late.
    logic [DW-1:0]    mem_a [N];
    logic [AW-1:0]    rpipe_a [LA];
    logic [AW+DW:0]   wq_a [2];
    logic             preload_a = 1'b0;
    always @(posedge clk) begin
        for (int i = LA - 1; i > 0; i--) rpipe_a[i] <= rpipe_a[i-1];
        rpipe_a[0] <= raddr_a;
        wq_a[0] <= {wen_a, waddr_a, wdata_a};
        wq_a[1] <= wq_a[0];
        if (preload_a) for (int i = 0; i < N; i++) mem_a[i] <= fill(i);
        else if (wq_a[1][AW+DW] === 1'b1) mem_a[wq_a[1][AW+DW-1:DW]] <= wq_a[1][DW-1:0];
    end
    assign rdata_a = mem_a[rpipe_a[LA-1]];

    logic [DW-1:0]    mem_b [N];
    logic [AW-1:0]    rpipe_b [LB];
    logic [AW+DW:0]   wq_b [2];
    logic             preload_b = 1'b0;
    always @(posedge clk) begin
        rpipe_b[2] <= rpipe_b[1];
        rpipe_b[1] <= rpipe_b[0];
        rpipe_b[0] <= raddr_b;
        wq_b[0] <= {wen_b, waddr_b, wdata_b};
        wq_b[1] <= wq_b[0];
        if (preload_b) for (int i = 0; i < N; i++) mem_b[i] <= fill(i);
        else if (wq_b[1][AW+DW] === 1'b1) mem_b[wq_b[1][AW+DW-1:DW]] <= wq_b[1][DW-1:0];
    end
    assign rdata_b = mem_b[rpipe_b[LB-1]];

    ent_t exp_a[$];
    ent_t exp_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_a, hs_a, done_cnt_a, first_a, donecyc_a, occ_a, occmax_a;
    int   cyc_b, hs_b, done_cnt_b, first_b, donecyc_b;
    logic wen_seen_b;

    // Called at a negedge with inputs already driven; consumes handshakes, advances one cycle.
    task automatic tick();
        ent_t e;
        if (valid_a && ready_a) begin
            hs_a++;
            n_cmp++;
            if (exp_a.size() == 0) begin
                n_bad++;
                $display("FAIL sb_a_extra: got id %0d, required no further word", id_a);
            end else begin
                e = exp_a.pop_front();
                if ({id_a, data_a} !== e) begin
                    n_bad++;
                    $display("FAIL sb_a_word: got id %0d data %h, required id %0d data %h",
                             id_a, data_a, e[DW+:AW], e[DW-1:0]);
                end
                n_cmp++;
                if (last_a !== (e[DW+:AW] == AW'(N - 1))) begin
                    n_bad++;
                    $display("FAIL sb_a_last: got %b at id %0d", last_a, e[DW+:AW]);
                end
            end
        end
        occ_a += int'(wen_a) - int'(valid_a && ready_a);
        if (occ_a > occmax_a) occmax_a = occ_a;
        if (valid_a && first_a < 0) first_a = cyc_a;
        if (done_a) begin done_cnt_a++; donecyc_a = cyc_a; end

        if (valid_b && ready_b) begin
            hs_b++;
            n_cmp++;
            if (exp_b.size() == 0) begin
                n_bad++;
                $display("FAIL sb_b_extra: got id %0d, required no further word", id_b);
            end else begin
                e = exp_b.pop_front();
                if ({id_b, data_b} !== e) begin
                    n_bad++;
                    $display("FAIL sb_b_word: got id %0d data %h, required id %0d data %h",
                             id_b, data_b, e[DW+:AW], e[DW-1:0]);
                end
                n_cmp++;
                if (last_b !== (e[DW+:AW] == AW'(N - 1))) begin
                    n_bad++;
                    $display("FAIL sb_b_last: got %b at id %0d", last_b, e[DW+:AW]);
                end
            end
        end
        if (valid_b && first_b < 0) first_b = cyc_b;
        if (done_b) begin done_cnt_b++; donecyc_b = cyc_b; end
        if (wen_b) wen_seen_b = 1'b1;

        @(posedge clk);
        cyc_a++;
        cyc_b++;
        @(negedge clk);
    endtask

    task automatic load_caches();
        preload_a = 1'b1;
        preload_b = 1'b1;
        tick();
        preload_a = 1'b0;
        preload_b = 1'b0;
    endtask

    task automatic begin_pass_a();
        exp_a.delete();
        for (int i = 0; i < N; i++) exp_a.push_back({AW'(i), fill(i)});
        hs_a = 0; done_cnt_a = 0; first_a = -1; donecyc_a = -1; occ_a = 0; occmax_a = 0;
        cyc_a = -1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic run_to_done_a(input int mode);
        int guard = 0;
        while (done_cnt_a == 0 && guard < 3000) begin
            if (mode == 1) ready_a = ~ready_a;
            tick();
            guard++;
        end
        ready_a = 1'b1;
        repeat (4) tick();
    endtask

    task automatic check_pass_a(input string tag);
        n_cmp++;
        if (hs_a !== N || exp_a.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_count: got %0d words (%0d left), required %0d (0 left)",
                     tag, hs_a, exp_a.size(), N);
        end
        n_cmp++;
        if (done_cnt_a !== 1) begin
            n_bad++;
            $display("FAIL %s_done: got %0d done pulses, required 1", tag, done_cnt_a);
        end
        n_cmp++;
        if (occmax_a > DEPTH_A) begin
            n_bad++;
            $display("FAIL %s_occupancy: got max %0d, required <= %0d", tag, occmax_a, DEPTH_A);
        end
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_busy_after: got %b, required 0", tag, busy_a);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy_a, done_a, raddr_a, waddr_a, wdata_a, wen_a, valid_a, data_a, id_a, last_a}
            !== '0) begin
            n_bad++;
            $display("FAIL reset_a_outputs: busy %b done %b raddr %0d wen %b valid %b id %0d",
                     busy_a, done_a, raddr_a, wen_a, valid_a, id_a);
        end
        n_cmp++;
        if ({busy_b, done_b, raddr_b, waddr_b, wdata_b, wen_b, valid_b, data_b, id_b, last_b}
            !== '0) begin
            n_bad++;
            $display("FAIL reset_b_outputs: busy %b done %b raddr %0d wen %b valid %b id %0d",
                     busy_b, done_b, raddr_b, wen_b, valid_b, id_b);
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_stream();
        int nz = 0;
        load_caches();
        ready_a = 1'b1;
        begin_pass_a();
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL stream_busy: got %b, required 1", busy_a);
        end
        run_to_done_a(0);
        check_pass_a("stream");
        n_cmp++;
        if (first_a !== LA + 1) begin
            n_bad++;
            $display("FAIL stream_first_valid: got cycle %0d, required %0d", first_a, LA + 1);
        end
        n_cmp++;
        if (donecyc_a !== N + LA + 1) begin
            n_bad++;
            $display("FAIL stream_done_cycle: got %0d, required %0d", donecyc_a, N + LA + 1);
        end
        for (int i = 0; i < N; i++) if (mem_a[i] !== '0) nz++;
        n_cmp++;
        if (nz !== 0) begin
            n_bad++;
            $display("FAIL stream_cleared: got %0d nonzero entries, required 0", nz);
        end
    endtask

    task automatic test_toggle_ready();
        load_caches();
        ready_a = 1'b0;
        begin_pass_a();
        run_to_done_a(1);
        check_pass_a("toggle");
    endtask

    task automatic test_stall();
        int guard = 0;
        int max_addr = 0;
        int addr_early = 0;
        int hs_before;
        load_caches();
        ready_a = 1'b1;
        begin_pass_a();
        while (hs_a < 10 && guard < 100) begin tick(); guard++; end
        ready_a = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (int'(raddr_a) > max_addr) max_addr = int'(raddr_a);
            if (i == 10) addr_early = int'(raddr_a);
            tick();
        end
        n_cmp++;
        if (max_addr > 10 + DEPTH_A) begin
            n_bad++;
            $display("FAIL stall_credit: got rd address %0d, required <= %0d",
                     max_addr, 10 + DEPTH_A);
        end
        n_cmp++;
        if (int'(raddr_a) !== addr_early) begin
            n_bad++;
            $display("FAIL stall_hold: got rd address %0d, required %0d", raddr_a, addr_early);
        end
        n_cmp++;
        if (hs_a !== 10) begin
            n_bad++;
            $display("FAIL stall_no_output: got %0d words, required 10", hs_a);
        end
        ready_a = 1'b1;
        hs_before = hs_a;
        tick();
        n_cmp++;
        if (hs_a !== hs_before + 1) begin
            n_bad++;
            $display("FAIL stall_resume: got %0d words, required %0d", hs_a, hs_before + 1);
        end
        run_to_done_a(0);
        check_pass_a("stall");
    endtask

    task automatic test_reset_mid_pass();
        int guard = 0;
        load_caches();
        ready_a = 1'b1;
        begin_pass_a();
        while (hs_a < 100 && guard < 300) begin tick(); guard++; end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy_a, done_a, raddr_a, waddr_a, wdata_a, wen_a, valid_a, data_a, id_a, last_a}
            !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: busy %b done %b raddr %0d wen %b valid %b id %0d",
                     busy_a, done_a, raddr_a, wen_a, valid_a, id_a);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_a.delete();
        occ_a = 0;
        repeat (20) tick();
        n_cmp++;
        if (done_cnt_a !== 0 || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_done: got %0d done pulses busy %b, required 0 and 0",
                     done_cnt_a, busy_a);
        end
        load_caches();
        begin_pass_a();
        run_to_done_a(0);
        check_pass_a("restart");
    endtask

    task automatic test_start_while_busy();
        int guard = 0;
        load_caches();
        ready_a = 1'b1;
        begin_pass_a();
        while (done_cnt_a == 0 && guard < 3000) begin
            start_a = (guard == 50 || guard == 200 || guard == N + 1);
            tick();
            guard++;
        end
        start_a = 1'b0;
        repeat (30) tick();
        check_pass_a("restart_ignored");
    endtask

    task automatic test_latency3_noclear();
        int guard = 0;
        int diff = 0;
        load_caches();
        exp_b.delete();
        for (int i = 0; i < N; i++) exp_b.push_back({AW'(i), fill(i)});
        hs_b = 0; done_cnt_b = 0; first_b = -1; donecyc_b = -1; wen_seen_b = 1'b0;
        ready_b = 1'b1;
        cyc_b = -1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        while (done_cnt_b == 0 && guard < 3000) begin tick(); guard++; end
        repeat (4) tick();
        n_cmp++;
        if (hs_b !== N || exp_b.size() !== 0 || done_cnt_b !== 1) begin
            n_bad++;
            $display("FAIL lat3_count: got %0d words %0d done, required %0d words 1 done",
                     hs_b, done_cnt_b, N);
        end
        n_cmp++;
        if (first_b !== LB + 1) begin
            n_bad++;
            $display("FAIL lat3_first_valid: got cycle %0d, required %0d", first_b, LB + 1);
        end
        n_cmp++;
        if (donecyc_b !== N + LB + 1) begin
            n_bad++;
            $display("FAIL lat3_done_cycle: got %0d, required %0d", donecyc_b, N + LB + 1);
        end
        n_cmp++;
        if (wen_seen_b !== 1'b0) begin
            n_bad++;
            $display("FAIL lat3_wr_enable: got %b, required 0", wen_seen_b);
        end
        for (int i = 0; i < N; i++) if (mem_b[i] !== fill(i)) diff++;
        n_cmp++;
        if (diff !== 0) begin
            n_bad++;
            $display("FAIL lat3_cache_kept: got %0d altered entries, required 0", diff);
        end
    endtask

    initial begin
        cyc_a = 0; hs_a = 0; done_cnt_a = 0; first_a = -1; donecyc_a = -1; occ_a = 0;
        occmax_a = 0;
        cyc_b = 0; hs_b = 0; done_cnt_b = 0; first_b = -1; donecyc_b = -1; wen_seen_b = 1'b0;
        test_reset();
        test_stream();
        test_toggle_ready();
        test_stall();
        test_reset_mid_pass();
        test_start_while_busy();
        test_latency3_noclear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
